// File: rtl/sasebo_simon.sv
// Simon128/128 encryption core behind a SASEBO-style handshake.
// One round per clock. The key schedule is generated alongside the rounds.
module sasebo_simon #(
    parameter int ROUNDS = 68
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic [767:0] Din,
    input  logic         Drdy,
    input  logic         EN,
    output logic [127:0] Dout,
    output logic         Dvld,
    output logic         BSY,
    output logic         Trig
);

    // z2 sequence stored leftmost-first, so Z2[i] is the constant bit for key step i.
    localparam logic [0:61] Z2 =
        62'b10101111011100000011010010011000101000010001111110010110110011;
    localparam logic [6:0] LAST_ROUND = 7'(ROUNDS - 1);

    logic [63:0] x, y, ka, kb;
    logic [6:0]  ctr;
    logic [5:0]  z_idx;
    logic        z_bit;
    logic [63:0] x_next, kb_next;
    logic        unused_din;

    // The low 512 bits of Din carry no information for this core.
    assign unused_din = ^Din[511:0];

    // The z2 index wraps at 62, so rounds 62..67 reuse the start of the sequence.
    assign z_idx = (ctr >= 7'd62) ? 6'(ctr - 7'd62) : ctr[5:0];
    assign z_bit = Z2[z_idx];

    assign x_next = y
                  ^ ({x[62:0], x[63]} & {x[55:0], x[63:56]})
                  ^ {x[61:0], x[63:62]}
                  ^ ka;

    assign kb_next = ~ka
                   ^ {kb[2:0], kb[63:3]}
                   ^ {kb[3:0], kb[63:4]}
                   ^ 64'h3
                   ^ {63'd0, z_bit};

    assign Trig = BSY;

    // NOTE: non-blocking assignments only in this block; every register sees pre-edge values.
    always_ff @(posedge CLK) begin
        if (RST) begin
            x    <= '0;
            y    <= '0;
            ka   <= '0;
            kb   <= '0;
            ctr  <= '0;
            Dout <= '0;
            Dvld <= 1'b0;
            BSY  <= 1'b0;
        end else begin
            Dvld <= 1'b0;
            if (BSY) begin
                x  <= x_next;
                y  <= x;
                ka <= kb;
                kb <= kb_next;
                if (ctr == LAST_ROUND) begin
                    Dout <= {x_next, x};
                    Dvld <= 1'b1;
                    BSY  <= 1'b0;
                    ctr  <= '0;
                end else begin
                    ctr <= ctr + 7'd1;
                end
            end else if (Drdy && EN) begin
                x   <= Din[767:704];
                y   <= Din[703:640];
                kb  <= Din[639:576];
                ka  <= Din[575:512];
                ctr <= '0;
                BSY <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sasebo_simon.sv
// Self-checking bench for sasebo_simon: random vectors against a loop-based Simon128/128 model.
// It also covers the handshake timing, ignored strobes, mid-run reset and back-to-back starts.
module tb_sasebo_simon;

    logic         CLK = 1'b0;
    logic         RST;
    logic [767:0] Din;
    logic         Drdy;
    logic         EN;
    logic [127:0] Dout;
    logic         Dvld;
    logic         BSY;
    logic         Trig;

    int tests_run = 0;
    int tests_failed = 0;

    localparam logic [127:0] VEC_PT  = 128'h6373656420737265_6c6c657661727420;
    localparam logic [127:0] VEC_KEY = 128'h0f0e0d0c0b0a0908_0706050403020100;
    localparam logic [127:0] VEC_CT  = 128'h49681b1e1e54fe3f_65aa832af84e0bbc;

    sasebo_simon dut (
        .CLK  (CLK),
        .RST  (RST),
        .Din  (Din),
        .Drdy (Drdy),
        .EN   (EN),
        .Dout (Dout),
        .Dvld (Dvld),
        .BSY  (BSY),
        .Trig (Trig)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] rol(input logic [63:0] v, input int n);
        return (v << n) | (v >> (64 - n));
    endfunction

    function automatic logic [63:0] ror(input logic [63:0] v, input int n);
        return (v >> n) | (v << (64 - n));
    endfunction

    // Reference model: expand the full key schedule first, then run the 68 Feistel rounds.
    function automatic logic [127:0] simon_model(input logic [127:0] pt, input logic [127:0] key);
        string       z2 = "10101111011100000011010010011000101000010001111110010110110011";
        logic [63:0] k [0:67];
        logic [63:0] x, y, t, zb;
        k[0] = key[63:0];
        k[1] = key[127:64];
        for (int i = 0; i < 66; i++) begin
            zb = (z2[i % 62] == "1") ? 64'd1 : 64'd0;
            k[i + 2] = 64'hFFFF_FFFF_FFFF_FFFC ^ zb ^ k[i]
                     ^ ror(k[i + 1], 3) ^ ror(ror(k[i + 1], 3), 1);
        end
        x = pt[127:64];
        y = pt[63:0];
        for (int i = 0; i < 68; i++) begin
            t = x;
            x = y ^ (rol(x, 1) & rol(x, 8)) ^ rol(x, 2) ^ k[i];
            y = t;
        end
        return {x, y};
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [511:0] rand512();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // mode 0: plain; mode 1: extra Drdy pulses while busy; mode 2: EN dropped mid-run.
    task automatic run_enc(input string tag, input logic [127:0] pt, input logic [127:0] key,
                           input logic [511:0] low, input logic [127:0] exp, input int mode);
        int k, busy, trig_bad, extra;
        logic [127:0] held;
        Din  = {pt, key, low};
        EN   = 1'b1;
        Drdy = 1'b1;
        tick();
        Drdy = 1'b0;
        k = 0; busy = 0; trig_bad = 0;
        while (!Dvld && k < 200) begin
            if (BSY) busy++;
            if (Trig !== BSY) trig_bad++;
            if (mode == 1) Drdy = (k % 7 == 3) && (k < 60);
            if (mode == 2 && k == 5) EN = 1'b0;
            tick();
            k++;
        end
        Drdy = 1'b0;
        check({tag, " latency"}, 128'(k), 128'd68);
        check({tag, " bsy_cycles"}, 128'(busy), 128'd68);
        check({tag, " bsy_at_dvld"}, 128'(BSY), 128'd0);
        check({tag, " trig"}, 128'(trig_bad), 128'd0);
        check({tag, " dout"}, Dout, exp);
        held = Dout;
        tick();
        check({tag, " dvld_1cyc"}, 128'(Dvld), 128'd0);
        extra = 0;
        for (int i = 0; i < ((mode == 0) ? 4 : 80); i++) begin
            if (Dvld || BSY || Dout !== held) extra++;
            tick();
        end
        check({tag, " quiet_after"}, 128'(extra), 128'd0);
        EN = 1'b1;
    endtask

    initial begin
        logic [127:0] pt, key, pt2, key2, exp_a, exp_b, held;
        int k, t, bad;

        RST = 1'b1; EN = 1'b0; Drdy = 1'b0; Din = '0;
        tick();
        tick();
        check("rst dout", Dout, 128'd0);
        check("rst dvld", 128'(Dvld), 128'd0);
        check("rst bsy", 128'(BSY), 128'd0);
        check("rst trig", 128'(Trig), 128'd0);
        RST = 1'b0;
        tick();

        // Known-answer vector.
        run_enc("kat", VEC_PT, VEC_KEY, 512'd0, VEC_CT, 0);

        // One plaintext bit changed, then the same with random ignored bits.
        pt = VEC_PT ^ 128'h1;
        run_enc("kat_pt21", pt, VEC_KEY, 512'd0, simon_model(pt, VEC_KEY), 0);
        check("kat_pt21 differs", 128'(Dout != VEC_CT), 128'd1);
        run_enc("low_ignored", pt, VEC_KEY, rand512(), simon_model(pt, VEC_KEY), 0);

        // Strobes while EN=0 must not start anything.
        held = Dout;
        EN = 1'b0; Drdy = 1'b1; bad = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (BSY || Dvld || Dout !== held) bad++;
        end
        Drdy = 1'b0; EN = 1'b1;
        check("en0 ignored", 128'(bad), 128'd0);

        // Strobes during BSY, then EN dropped mid-run.
        pt = rand128(); key = rand128();
        run_enc("busy_strobe", pt, key, rand512(), simon_model(pt, key), 1);
        pt = rand128(); key = rand128();
        run_enc("en_drop", pt, key, 512'd0, simon_model(pt, key), 2);

        // Reset at round 30 aborts the run.
        pt = rand128(); key = rand128();
        Din = {pt, key, 512'd0}; EN = 1'b1; Drdy = 1'b1;
        tick();
        Drdy = 1'b0;
        for (int i = 0; i < 30; i++) tick();
        RST = 1'b1;
        tick();
        RST = 1'b0;
        check("midrst bsy", 128'(BSY), 128'd0);
        check("midrst dvld", 128'(Dvld), 128'd0);
        check("midrst dout", Dout, 128'd0);
        check("midrst trig", 128'(Trig), 128'd0);
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (BSY || Dvld) bad++;
        end
        check("midrst stays idle", 128'(bad), 128'd0);
        run_enc("after_rst", pt, key, 512'd0, simon_model(pt, key), 0);

        // Drdy held high: second start on the edge right after Dvld.
        pt = rand128(); key = rand128(); pt2 = rand128(); key2 = rand128();
        exp_a = simon_model(pt, key);
        exp_b = simon_model(pt2, key2);
        Din = {pt, key, 512'd0}; EN = 1'b1; Drdy = 1'b1;
        tick();
        k = 0;
        while (!Dvld && k < 200) begin
            tick();
            k++;
        end
        check("b2b first latency", 128'(k), 128'd68);
        check("b2b first dout", Dout, exp_a);
        Din = {pt2, key2, rand512()};
        t = 0;
        do begin
            tick();
            t++;
            if (t == 1) Drdy = 1'b0;
        end while (!Dvld && t < 300);
        check("b2b spacing", 128'(t), 128'd69);
        check("b2b second dout", Dout, exp_b);
        tick();

        // Corner keys and a few random vectors.
        run_enc("zeros", 128'd0, 128'd0, 512'd0, simon_model(128'd0, 128'd0), 0);
        run_enc("ones", '1, '1, '1, simon_model('1, '1), 0);
        for (int n = 0; n < 4; n++) begin
            pt = rand128(); key = rand128();
            run_enc($sformatf("rand%0d", n), pt, key, rand512(), simon_model(pt, key), 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
